color_centroid_tracker: RTL and testbench
=========================================

# color_centroid_tracker

Downstream consumer of the video decoding pipeline's 10-bit RGB pixel stream. It rebuilds pixel coordinates from the data-valid strobe and vertical sync. Each pixel is classified against fixed colour thresholds, and the block accumulates count, coordinate sums and bounding box of matching pixels per frame. At each frame boundary it computes the integer centroid with a sequential divider and publishes one result per frame to the tracking logic.

## Interface
- H_ACTIVE, 640, active pixels per line (post down-sample).
- V_ACTIVE, 480, active lines per frame.
- R_MIN, 10'd700, match requires R >= R_MIN.
- G_MAX, 10'd300, match requires G <= G_MAX.
- B_MAX, 10'd300, match requires B <= B_MAX.
- MIN_PIXELS, 16, minimum match count for a valid detection.
- iCLK  in  1  pixel clock (27 MHz domain), sole clock.
- iRESET  in  1  synchronous, active-high reset.
- iR, iG, iB  in  10 each  pixel colour.
- iDVAL  in  1  pixel valid, one pixel per asserted cycle.
- iVS  in  1  vertical sync, active low.
- oX, oY  out  10 each  centroid (floor of mean).
- oMinX, oMaxX, oMinY, oMaxY  out  10 each  bounding box.
- oCount  out  19  matching pixels in last frame.
- oFound  out  1  oCount >= MIN_PIXELS.
- oValid  out  1  one-cycle pulse, new result on outputs.

## Operation
- Frame edge: iVS registered; an edge is detected in the cycle where iVS=0 and the registered previous value is 1.
- States: WAIT_FRAME (after reset), ACCUM, DIV_X, DIV_Y, PUBLISH.
- WAIT_FRAME: iDVAL is ignored. A frame edge moves to ACCUM with counters cleared.
- Coordinates: x increments on each iDVAL. When x=H_ACTIVE-1 it wraps to 0 and y increments. Once y reaches V_ACTIVE it saturates, and further pixels are ignored until the next edge.
- Edge-cycle pixel: a pixel with iDVAL in the edge cycle is pixel (0,0) of the new frame.
- Match on accepted pixels (R>=R_MIN && G<=G_MAX && B<=B_MAX):
  - count+=1; sum_x+=x (28 bit); sum_y+=y (28 bit).
  - min/max registers updated. They initialise to minX=minY=1023 and maxX=maxY=0 at each edge.
- On frame edge while in ACCUM:
  - Snapshot count, sums and bbox into result registers.
  - Clear the accumulators the same cycle; accumulation of the new frame proceeds concurrently.
  - If snapshot count >= MIN_PIXELS, go to DIV_X; otherwise go to PUBLISH with oFound=0.
- DIV_X: 28-iteration restoring divide sum_x / count, one quotient bit per cycle. The quotient is truncated to 10 bits (it is always < H_ACTIVE). DIV_Y does the same for sum_y, then goes to PUBLISH.
- PUBLISH updates outputs and pulses oValid, then returns to ACCUM.
- When oFound=0: oX, oY hold their previous values. oCount and bbox still update; an empty frame reports bbox 1023/0/1023/0.
- Frame edge during DIV_X/DIV_Y: the in-flight divide is discarded, the new snapshot is taken, and the divide restarts in DIV_X. No oValid is issued for the discarded frame.
- Counts never overflow: V_ACTIVE*H_ACTIVE < 2^19.

## Timing
- Reset: all outputs 0, state WAIT_FRAME, accumulators cleared. Reset takes priority over any edge in the same cycle.
- Reset mid-operation aborts any divide with no oValid. Accumulation resumes only after the next frame edge.
- Edge at cycle N, found: DIV_X covers N+1..N+28, DIV_Y covers N+29..N+56. Outputs change and oValid=1 at N+57.
- Edge at cycle N, not found: outputs change and oValid=1 at N+1.
- Outputs are stable between oValid pulses. oValid is never high for two consecutive cycles.
- Accumulation has single-cycle throughput: iDVAL may be high every cycle. There is no backpressure.

## Test plan
- Reset: assert iRESET 2 cycles with random inputs -> all outputs 0. oValid stays 0 until the second frame edge.
- Square target, 640x480 frame: R=1023,G=B=0 at x 100..109, y 50..59, black elsewhere; next edge at N -> at N+57 oValid=1, oX=104, oY=54, bbox 100/109/50/59, oCount=100, oFound=1.
- Below threshold: next frame has 10 matching pixels -> oValid at N+1, oCount=10, oFound=0, oX/oY still 104/54.
- Corner pixel: a single match at (639,479) with MIN_PIXELS=1 -> oX=639, oY=479, bbox 639/639/479/479.
- Overrun/wrap: feed 640*480+50 valid pixels, with the extra 50 matching -> oCount=0, oFound=0. Also check that line wrap places pixel 640 at (0,1).
- Early edge and mid-reset:
  - Edge at N+10 during DIV_X -> no oValid for the first frame; oValid at N+67 reflects the second snapshot.
  - iRESET during DIV_Y -> outputs 0 and no oValid.

Source files
------------

// File: rtl/color_centroid_tracker_if.sv
// Pixel stream in, per-frame centroid result out.
// The master drives pixels and the slave returns the result.
interface color_centroid_tracker_if;
    logic [9:0]  iR, iG, iB;
    logic        iDVAL;
    logic        iVS;
    logic [9:0]  oX, oY;
    logic [9:0]  oMinX, oMaxX, oMinY, oMaxY;
    logic [18:0] oCount;
    logic        oFound;
    logic        oValid;

    modport master (
        output iR, iG, iB, iDVAL, iVS,
        input  oX, oY, oMinX, oMaxX, oMinY, oMaxY, oCount, oFound, oValid
    );

    modport slave (
        input  iR, iG, iB, iDVAL, iVS,
        output oX, oY, oMinX, oMaxX, oMinY, oMaxY, oCount, oFound, oValid
    );
endinterface

// File: rtl/color_centroid_tracker.sv
// Colour-threshold centroid tracker. It rebuilds x/y from DVAL and VS and
// accumulates the matching pixels of each frame. At every frame edge it
// takes a snapshot, divides the sums by the count, and publishes one
// result for the frame.
module color_centroid_tracker #(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [9:0] R_MIN      = 10'd700,
    parameter logic [9:0] G_MAX      = 10'd300,
    parameter logic [9:0] B_MAX      = 10'd300,
    parameter int         MIN_PIXELS = 16
) (
    input logic                     iCLK,
    input logic                     iRESET,
    color_centroid_tracker_if.slave bus
);
    typedef enum logic [2:0] {WAIT_FRAME, ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;
    state_t state, state_n;

    logic        vs_q, frame_edge, snap, snap_found, pend;
    logic [9:0]  x, y, min_x, max_x, min_y, max_y;
    logic [18:0] count;
    logic [27:0] sum_x, sum_y;

    // base values: the current frame, or an empty frame in the edge cycle
    logic [9:0]  bx, by, bmin_x, bmax_x, bmin_y, bmax_y;
    logic [18:0] bcount;
    logic [27:0] bsum_x, bsum_y;
    logic        take, hit;
    logic [9:0]  x_n, y_n, min_x_n, max_x_n, min_y_n, max_y_n;
    logic [18:0] count_n;
    logic [27:0] sum_x_n, sum_y_n;

    // snapshot of the closed frame
    logic [9:0]  res_min_x, res_max_x, res_min_y, res_max_y, res_qx;
    logic [18:0] res_count;
    logic [27:0] res_sum_y;
    logic        res_found;

    // restoring divider: the dividend shifts out of div_q as the quotient shifts in
    logic [28:0] div_rem, trial, rem_n;
    logic [27:0] div_q, q_n;
    logic [18:0] div_den;
    logic [4:0]  div_cnt;
    logic        div_last, ge;

    // publish source: the live accumulators when publishing straight from the edge
    logic        pub, src_found;
    logic [18:0] src_count;
    logic [9:0]  src_min_x, src_max_x, src_min_y, src_max_y;

    assign frame_edge = !bus.iVS && vs_q;
    assign snap       = frame_edge && (state != WAIT_FRAME);
    assign snap_found = count >= 19'(MIN_PIXELS);
    assign div_last   = (div_cnt == 5'd27);

    // next accumulator values for one pixel
    always_comb begin
        bx = x; by = y; bcount = count; bsum_x = sum_x; bsum_y = sum_y;
        bmin_x = min_x; bmax_x = max_x; bmin_y = min_y; bmax_y = max_y;
        if (frame_edge) begin
            bx = '0; by = '0; bcount = '0; bsum_x = '0; bsum_y = '0;
            bmin_x = 10'h3FF; bmax_x = '0; bmin_y = 10'h3FF; bmax_y = '0;
        end
        take = (frame_edge || state != WAIT_FRAME) && bus.iDVAL && (by < 10'(V_ACTIVE));
        hit  = take && (bus.iR >= R_MIN) && (bus.iG <= G_MAX) && (bus.iB <= B_MAX);
        x_n = bx; y_n = by; count_n = bcount; sum_x_n = bsum_x; sum_y_n = bsum_y;
        min_x_n = bmin_x; max_x_n = bmax_x; min_y_n = bmin_y; max_y_n = bmax_y;
        if (take) begin
            if (bx == 10'(H_ACTIVE - 1)) begin
                x_n = '0;
                y_n = by + 10'd1;
            end else begin
                x_n = bx + 10'd1;
            end
        end
        if (hit) begin
            count_n = bcount + 19'd1;
            sum_x_n = bsum_x + 28'(bx);
            sum_y_n = bsum_y + 28'(by);
            if (bx < bmin_x) min_x_n = bx;
            if (bx > bmax_x) max_x_n = bx;
            if (by < bmin_y) min_y_n = by;
            if (by > bmax_y) max_y_n = by;
        end
    end

    // accumulators and the sync history
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            vs_q <= 1'b0;
            x <= '0; y <= '0; count <= '0; sum_x <= '0; sum_y <= '0;
            min_x <= 10'h3FF; max_x <= '0; min_y <= 10'h3FF; max_y <= '0;
        end else begin
            vs_q <= bus.iVS;
            x <= x_n; y <= y_n; count <= count_n; sum_x <= sum_x_n; sum_y <= sum_y_n;
            min_x <= min_x_n; max_x <= max_x_n; min_y <= min_y_n; max_y <= max_y_n;
        end
    end

    // one restoring divide step
    always_comb begin
        trial = {div_rem[27:0], div_q[27]};
        ge    = trial >= {10'd0, div_den};
        rem_n = ge ? trial - {10'd0, div_den} : trial;
        q_n   = {div_q[26:0], ge};
    end

    // state register
    always_ff @(posedge iCLK) begin
        if (iRESET) state <= WAIT_FRAME;
        else        state <= state_n;
    end

    // next state. An edge landing in PUBLISH with a small count is deferred
    // by one cycle so oValid never pulses twice in a row.
    always_comb begin
        state_n = state;
        case (state)
            WAIT_FRAME: if (frame_edge) state_n = ACCUM;
            ACCUM:      if (pend) state_n = PUBLISH;
            DIV_X:      if (div_last) state_n = DIV_Y;
            DIV_Y:      if (div_last) state_n = PUBLISH;
            PUBLISH:    state_n = ACCUM;
            default:    state_n = WAIT_FRAME;
        endcase
        if (snap) begin
            if (snap_found)              state_n = DIV_X;
            else if (state == PUBLISH)   state_n = ACCUM;
            else                         state_n = PUBLISH;
        end
    end

    // snapshot, divider and deferred-publish flag
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            res_count <= '0; res_sum_y <= '0; res_found <= 1'b0; res_qx <= '0;
            res_min_x <= '0; res_max_x <= '0; res_min_y <= '0; res_max_y <= '0;
            div_rem <= '0; div_q <= '0; div_den <= '0; div_cnt <= '0;
            pend <= 1'b0;
        end else begin
            if (state == ACCUM) pend <= 1'b0;
            if (snap) begin
                res_count <= count; res_sum_y <= sum_y; res_found <= snap_found;
                res_min_x <= min_x; res_max_x <= max_x; res_min_y <= min_y; res_max_y <= max_y;
                div_rem <= '0; div_q <= sum_x; div_den <= count; div_cnt <= '0;
                pend <= !snap_found && (state == PUBLISH);
            end else if (state == DIV_X || state == DIV_Y) begin
                if (div_last) begin
                    div_cnt <= '0;
                    div_rem <= '0;
                    if (state == DIV_X) begin
                        res_qx <= q_n[9:0];
                        div_q  <= res_sum_y;
                    end else begin
                        div_q  <= q_n;
                    end
                end else begin
                    div_cnt <= div_cnt + 5'd1;
                    div_rem <= rem_n;
                    div_q   <= q_n;
                end
            end
        end
    end

    // publish mux
    always_comb begin
        pub       = (state_n == PUBLISH);
        src_found = !snap && res_found;
        src_count = snap ? count : res_count;
        src_min_x = snap ? min_x : res_min_x;
        src_max_x = snap ? max_x : res_max_x;
        src_min_y = snap ? min_y : res_min_y;
        src_max_y = snap ? max_y : res_max_y;
    end

    // result outputs, held between publishes
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            bus.oX <= '0; bus.oY <= '0; bus.oCount <= '0; bus.oFound <= 1'b0; bus.oValid <= 1'b0;
            bus.oMinX <= '0; bus.oMaxX <= '0; bus.oMinY <= '0; bus.oMaxY <= '0;
        end else begin
            bus.oValid <= pub;
            if (pub) begin
                bus.oCount <= src_count;
                bus.oFound <= src_found;
                bus.oMinX  <= src_min_x;
                bus.oMaxX  <= src_max_x;
                bus.oMinY  <= src_min_y;
                bus.oMaxY  <= src_max_y;
                if (src_found) begin
                    bus.oX <= res_qx;
                    bus.oY <= q_n[9:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_color_centroid_tracker.sv
// Directed bench for the centroid tracker on a reduced 128x64 raster.
// dut_a uses the default 16-pixel threshold and dut_b a threshold of one;
// both see the same pixel stream.
module tb_color_centroid_tracker;
    localparam int H = 128;
    localparam int V = 64;

    logic clk, rst;
    int   total, bad;

    color_centroid_tracker_if ifa ();
    color_centroid_tracker_if ifb ();

    color_centroid_tracker #(.H_ACTIVE(H), .V_ACTIVE(V)) dut_a (
        .iCLK(clk), .iRESET(rst), .bus(ifa.slave));
    color_centroid_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(1)) dut_b (
        .iCLK(clk), .iRESET(rst), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                        input logic dval, input logic vs);
        ifa.iR = r; ifa.iG = g; ifa.iB = b; ifa.iDVAL = dval; ifa.iVS = vs;
        ifb.iR = r; ifb.iG = g; ifb.iB = b; ifb.iDVAL = dval; ifb.iVS = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    endtask

    task automatic vs_edge(input logic with_hit);
        step(with_hit ? 10'd1023 : 10'd0, 10'd0, 10'd0, with_hit, 1'b0);
    endtask

    function automatic logic vld(input int w);
        return (w == 0) ? ifa.oValid : ifb.oValid;
    endfunction

    // Idle until the chosen DUT pulses oValid; n = idle cycles spent.
    task automatic wait_valid(input int w, input int maxc, output int n);
        n = 0;
        while (vld(w) !== 1'b1 && n < maxc) begin
            idle();
            n++;
        end
    endtask

    // Feed n pixels in raster order. Matches alternate the saturated colour
    // and the exact threshold colour; misses sit one code past each threshold.
    task automatic send_pixels(input int n, input int mode);
        int  px, py;
        logic m;
        for (int k = 0; k < n; k++) begin
            px = k % H;
            py = k / H;
            case (mode)
                0: m = (px >= 100 && px <= 109 && py >= 50 && py <= 59);
                1: m = (k < 10);
                2: m = (k == H * V - 1);
                3: m = (k >= H * V);
                4: m = (k == H);
                default: m = 1'b0;
            endcase
            if (m) begin
                if (k % 2 == 1) step(10'd700, 10'd300, 10'd300, 1'b1, 1'b1);
                else            step(10'd1023, 10'd0, 10'd0, 1'b1, 1'b1);
            end else begin
                case (k % 4)
                    0: step(10'd699, 10'd0, 10'd0, 1'b1, 1'b1);
                    1: step(10'd1023, 10'd301, 10'd0, 1'b1, 1'b1);
                    2: step(10'd1023, 10'd0, 10'd301, 1'b1, 1'b1);
                    default: step(10'd0, 10'd0, 10'd0, 1'b1, 1'b1);
                endcase
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            step(10'($urandom), 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
        total++;
        if ({ifa.oX, ifa.oY, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY, ifa.oCount, ifa.oFound, ifa.oValid} !== '0) begin
            bad++; $display("FAIL reset_a outputs=%h want=0",
                {ifa.oX, ifa.oY, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY, ifa.oCount, ifa.oFound, ifa.oValid});
        end
        total++;
        if ({ifb.oX, ifb.oY, ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY, ifb.oCount, ifb.oFound, ifb.oValid} !== '0) begin
            bad++; $display("FAIL reset_b outputs=%h want=0",
                {ifb.oX, ifb.oY, ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY, ifb.oCount, ifb.oFound, ifb.oValid});
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (ifa.oValid === 1'b1 || ifb.oValid === 1'b1) seen++;
        end
        vs_edge(1'b0);
        if (ifa.oValid === 1'b1 || ifb.oValid === 1'b1) seen++;
        for (int i = 0; i < 70; i++) begin
            idle();
            if (ifa.oValid === 1'b1 || ifb.oValid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_first_edge valid_pulses=%0d want=0", seen); end
    endtask

    task automatic test_square();
        int n;
        send_pixels(60 * H, 0);
        vs_edge(1'b0);
        wait_valid(0, 80, n);
        total++; if (n !== 56) begin bad++; $display("FAIL sq_latency got=%0d want=56", n); end
        total++; if (ifa.oX !== 10'd104) begin bad++; $display("FAIL sq_x got=%0d want=104", ifa.oX); end
        total++; if (ifa.oY !== 10'd54) begin bad++; $display("FAIL sq_y got=%0d want=54", ifa.oY); end
        total++;
        if ({ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !== {10'd100, 10'd109, 10'd50, 10'd59}) begin
            bad++; $display("FAIL sq_bbox got=%0d/%0d/%0d/%0d want=100/109/50/59",
                ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
        total++; if (ifa.oCount !== 19'd100) begin bad++; $display("FAIL sq_count got=%0d want=100", ifa.oCount); end
        total++; if (ifa.oFound !== 1'b1) begin bad++; $display("FAIL sq_found got=%0b want=1", ifa.oFound); end
        idle();
        total++; if (ifa.oValid !== 1'b0) begin bad++; $display("FAIL sq_pulse_width valid=%0b want=0", ifa.oValid); end
    endtask

    task automatic test_below();
        send_pixels(10, 1);
        vs_edge(1'b0);
        total++; if (ifa.oValid !== 1'b1) begin bad++; $display("FAIL below_latency valid=%0b want=1", ifa.oValid); end
        total++; if (ifa.oCount !== 19'd10) begin bad++; $display("FAIL below_count got=%0d want=10", ifa.oCount); end
        total++; if (ifa.oFound !== 1'b0) begin bad++; $display("FAIL below_found got=%0b want=0", ifa.oFound); end
        total++;
        if ({ifa.oX, ifa.oY} !== {10'd104, 10'd54}) begin
            bad++; $display("FAIL below_hold_xy got=%0d/%0d want=104/54", ifa.oX, ifa.oY);
        end
        total++;
        if ({ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !== {10'd0, 10'd9, 10'd0, 10'd0}) begin
            bad++; $display("FAIL below_bbox got=%0d/%0d/%0d/%0d want=0/9/0/0",
                ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 60; i++) idle();
        vs_edge(1'b0);
        total++; if (ifa.oValid !== 1'b1) begin bad++; $display("FAIL empty_latency valid=%0b want=1", ifa.oValid); end
        total++;
        if ({ifa.oCount, ifa.oFound} !== {19'd0, 1'b0}) begin
            bad++; $display("FAIL empty_count got=%0d found=%0b want=0/0", ifa.oCount, ifa.oFound);
        end
        total++;
        if ({ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !== {10'd1023, 10'd0, 10'd1023, 10'd0}) begin
            bad++; $display("FAIL empty_bbox got=%0d/%0d/%0d/%0d want=1023/0/1023/0",
                ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
        total++; if (ifa.oX !== 10'd104) begin bad++; $display("FAIL empty_hold_x got=%0d want=104", ifa.oX); end
    endtask

    task automatic test_line_wrap();
        int n;
        send_pixels(H + 1, 4);
        vs_edge(1'b0);
        total++;
        if ({ifa.oValid, ifa.oCount, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !==
            {1'b1, 19'd1, 10'd0, 10'd0, 10'd1, 10'd1}) begin
            bad++; $display("FAIL wrap_a valid=%0b count=%0d bbox=%0d/%0d/%0d/%0d want=1 1 0/0/1/1",
                ifa.oValid, ifa.oCount, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
        wait_valid(1, 80, n);
        total++; if (n !== 56) begin bad++; $display("FAIL wrap_b_latency got=%0d want=56", n); end
        total++;
        if ({ifb.oX, ifb.oY, ifb.oFound} !== {10'd0, 10'd1, 1'b1}) begin
            bad++; $display("FAIL wrap_b_xy got=%0d/%0d found=%0b want=0/1 1", ifb.oX, ifb.oY, ifb.oFound);
        end
    endtask

    task automatic test_corner();
        int n;
        send_pixels(H * V, 2);
        vs_edge(1'b0);
        total++;
        if ({ifa.oValid, ifa.oCount, ifa.oFound} !== {1'b1, 19'd1, 1'b0}) begin
            bad++; $display("FAIL corner_a valid=%0b count=%0d found=%0b want=1 1 0",
                ifa.oValid, ifa.oCount, ifa.oFound);
        end
        wait_valid(1, 80, n);
        total++; if (n !== 56) begin bad++; $display("FAIL corner_b_latency got=%0d want=56", n); end
        total++;
        if ({ifb.oX, ifb.oY} !== {10'd127, 10'd63}) begin
            bad++; $display("FAIL corner_b_xy got=%0d/%0d want=127/63", ifb.oX, ifb.oY);
        end
        total++;
        if ({ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY, ifb.oCount} !==
            {10'd127, 10'd127, 10'd63, 10'd63, 19'd1}) begin
            bad++; $display("FAIL corner_b_bbox got=%0d/%0d/%0d/%0d count=%0d want=127/127/63/63 1",
                ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY, ifb.oCount);
        end
    endtask

    task automatic test_edge_pixel();
        int n;
        vs_edge(1'b1);
        for (int i = 0; i < 60; i++) idle();
        vs_edge(1'b0);
        total++;
        if ({ifa.oValid, ifa.oCount, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !==
            {1'b1, 19'd1, 10'd0, 10'd0, 10'd0, 10'd0}) begin
            bad++; $display("FAIL edgepix_a valid=%0b count=%0d bbox=%0d/%0d/%0d/%0d want=1 1 0/0/0/0",
                ifa.oValid, ifa.oCount, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
        wait_valid(1, 80, n);
        total++;
        if ({n[7:0], ifb.oX, ifb.oY, ifb.oFound} !== {8'd56, 10'd0, 10'd0, 1'b1}) begin
            bad++; $display("FAIL edgepix_b lat=%0d xy=%0d/%0d found=%0b want=56 0/0 1",
                n, ifb.oX, ifb.oY, ifb.oFound);
        end
    endtask

    task automatic test_overrun();
        send_pixels(H * V + 50, 3);
        vs_edge(1'b0);
        total++;
        if ({ifa.oValid, ifa.oCount, ifa.oFound} !== {1'b1, 19'd0, 1'b0}) begin
            bad++; $display("FAIL overrun_a valid=%0b count=%0d found=%0b want=1 0 0",
                ifa.oValid, ifa.oCount, ifa.oFound);
        end
        total++;
        if ({ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY} !== {10'd1023, 10'd0, 10'd1023, 10'd0}) begin
            bad++; $display("FAIL overrun_bbox got=%0d/%0d/%0d/%0d want=1023/0/1023/0",
                ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY);
        end
        total++;
        if ({ifb.oValid, ifb.oCount, ifb.oFound} !== {1'b1, 19'd0, 1'b0}) begin
            bad++; $display("FAIL overrun_b valid=%0b count=%0d found=%0b want=1 0 0",
                ifb.oValid, ifb.oCount, ifb.oFound);
        end
    endtask

    task automatic test_early_edge();
        int n, seen;
        send_pixels(60 * H, 0);
        vs_edge(1'b0);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(10'd1023, 10'd0, 10'd0, 1'b1, 1'b1);
            if (ifa.oValid === 1'b1 || ifb.oValid === 1'b1) seen++;
        end
        vs_edge(1'b0);
        if (ifb.oValid === 1'b1) seen++;
        total++; if (seen !== 0) begin bad++; $display("FAIL early_discard valid_pulses=%0d want=0", seen); end
        total++;
        if ({ifa.oValid, ifa.oCount, ifa.oFound} !== {1'b1, 19'd9, 1'b0}) begin
            bad++; $display("FAIL early_a valid=%0b count=%0d found=%0b want=1 9 0",
                ifa.oValid, ifa.oCount, ifa.oFound);
        end
        wait_valid(1, 80, n);
        total++; if (n !== 56) begin bad++; $display("FAIL early_b_latency got=%0d want=56", n); end
        total++;
        if ({ifb.oX, ifb.oY, ifb.oCount, ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY} !==
            {10'd4, 10'd0, 19'd9, 10'd0, 10'd8, 10'd0, 10'd0}) begin
            bad++; $display("FAIL early_b_result xy=%0d/%0d count=%0d bbox=%0d/%0d/%0d/%0d want=4/0 9 0/8/0/0",
                ifb.oX, ifb.oY, ifb.oCount, ifb.oMinX, ifb.oMaxX, ifb.oMinY, ifb.oMaxY);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        send_pixels(60 * H, 0);
        vs_edge(1'b0);
        for (int i = 0; i < 40; i++) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        total++;
        if ({ifa.oX, ifa.oY, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY, ifa.oCount, ifa.oFound, ifa.oValid} !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%h want=0",
                {ifa.oX, ifa.oY, ifa.oMinX, ifa.oMaxX, ifa.oMinY, ifa.oMaxY, ifa.oCount, ifa.oFound, ifa.oValid});
        end
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            idle();
            if (ifa.oValid === 1'b1 || ifb.oValid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_valid pulses=%0d want=0", seen); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ifa.iR = '0; ifa.iG = '0; ifa.iB = '0; ifa.iDVAL = 1'b0; ifa.iVS = 1'b1;
        ifb.iR = '0; ifb.iG = '0; ifb.iB = '0; ifb.iDVAL = 1'b0; ifb.iVS = 1'b1;
        test_reset();
        test_square();
        test_below();
        test_empty();
        test_line_wrap();
        test_corner();
        test_edge_pixel();
        test_overrun();
        test_early_edge();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
